rca_multiword_adder: RTL and testbench



---
 rtl/rca_multiword_adder_pkg.sv | 12 +
 rtl/RCA_4bit.sv | 25 ++
 rtl/rca_multiword_adder.sv | 100 ++++++++++
 tb/tb_rca_multiword_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_multiword_adder_pkg.sv
// rtl/rca_multiword_adder_pkg.sv - shared constants and state type for the multiword adder
package rca_multiword_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/RCA_4bit.sv
// rtl/RCA_4bit.sv - 4-bit ripple-carry adder slice
module RCA_4bit
  import rca_multiword_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/rca_multiword_adder.sv
// rtl/rca_multiword_adder.sv - WIDTH-bit adder, one nibble per cycle; RCA_MULTIWORD_OVF_EN adds ovf output
module rca_multiword_adder
  import rca_multiword_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_MULTIWORD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e              state_q;
  logic [WIDTH-1:0]    a_q, b_q, sum_q;
  logic                carry_q, cout_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic                carry_d;

  assign a_nib = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
  assign b_nib = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

  RCA_4bit u_slice (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .sum (sum_nib),
    .cout(carry_d)
  );

`ifdef RCA_MULTIWORD_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef RCA_MULTIWORD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= sum_nib;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= carry_d;
`ifdef RCA_MULTIWORD_OVF_EN
            // carry into the MSB differs from carry out of it
            ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_nib[NIBBLE_W-1]) ^ carry_d;
`endif
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_rca_multiword_adder.sv
// tb/tb_rca_multiword_adder.sv - directed self-checking bench for rca_multiword_adder
module tb_rca_multiword_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef RCA_MULTIWORD_OVF_EN
  logic        ovf;
`endif

  int vectors;
  int miscompares;

  rca_multiword_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef RCA_MULTIWORD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic start_add(input logic [15:0] av, input logic [15:0] bv, input logic c);
    a = av;
    b = bv;
    cin = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    vectors++;
    if (sum !== 16'h0000 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: sum=%h cout=%b, expected 0000 0", sum, cout);
    end
`ifdef RCA_MULTIWORD_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: ovf=%b, expected 0", ovf);
    end
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    vec_t tbl[6];
    int n;
    tbl[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      start_add(tbl[i].a, tbl[i].b, tbl[i].cin);
      wait_done(n);
      vectors++;
      if (n !== 4) begin
        miscompares++;
        $display("FAIL add%0d_latency: %0d edges, expected 4", i, n);
      end
      vectors++;
      if (sum !== tbl[i].sum || cout !== tbl[i].cout) begin
        miscompares++;
        $display("FAIL add%0d_result: sum=%h cout=%b, expected %h %b", i, sum, cout, tbl[i].sum, tbl[i].cout);
      end
`ifdef RCA_MULTIWORD_OVF_EN
      vectors++;
      if (ovf !== tbl[i].ovf) begin
        miscompares++;
        $display("FAIL add%0d_ovf: ovf=%b, expected %b", i, ovf, tbl[i].ovf);
      end
`endif
      release_result();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL add%0d_release: in_ready=%b out_valid=%b, expected 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    start_add(16'hABCD, 16'h1111, 1'b0);
    wait_done(n);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'hBCDE || cout !== 1'b0) begin
        miscompares++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b, expected 1 0 bcde 0",
                 i, out_valid, in_ready, sum, cout);
      end
      @(posedge clk);
      #1;
    end
    release_result();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start_add(16'h1111, 16'h2222, 1'b0);
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      a = 16'(n * 16'h1357);
      b = ~a;
      cin = n[0];
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (sum !== 16'h3333 || cout !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_result: sum=%h cout=%b in_ready=%b, expected 3333 0 0", sum, cout, in_ready);
    end
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_idle: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL second_accept: in_ready=%b, expected 0", in_ready);
    end
    wait_done(n);
    vectors++;
    if (n !== 4 || sum !== 16'hFFFF || cout !== 1'b1) begin
      miscompares++;
      $display("FAIL second_result: edges=%0d sum=%h cout=%b, expected 4 ffff 1", n, sum, cout);
    end
    release_result();
  endtask

  task automatic test_reset_midrun();
    int n;
    start_add(16'h5555, 16'h5555, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: out_valid=%b in_ready=%b sum=%h cout=%b, expected 0 1 0000 0",
               out_valid, in_ready, sum, cout);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_add(16'h00FF, 16'h0F01, 1'b0);
    wait_done(n);
    vectors++;
    if (n !== 4 || sum !== 16'h1000 || cout !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_add: edges=%0d sum=%h cout=%b, expected 4 1000 0", n, sum, cout);
    end
    release_result();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    test_reset();
    test_add();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
